// File: rtl/alu_result_mux_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mux_pkg (package)
//  Purpose  : Shared encodings for the ALU result multiplexer pipeline:
//             skid-buffer occupancy states and selection-mode constants.
//  Contents : occ_state_t  - EMPTY / ONE / TWO buffered entries
//             MODE_EXPLICIT, MODE_RR - values of the mode input
//  Revision : 1.0 - initial release
// ============================================================================
package alu_mux_pkg;

    // Number of entries currently held in the two-deep output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    localparam logic MODE_EXPLICIT = 1'b0;
    localparam logic MODE_RR       = 1'b1;

endpackage : alu_mux_pkg
`default_nettype wire

// File: rtl/alu_result_mux_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_mux_pipe_if
//  Purpose  : Bundles the channel inputs, selection controls and the
//             valid/ready output of the ALU result multiplexer.
//  Ports    : master - driven by the ALU side / downstream consumer
//             slave  - the multiplexer itself
//  Signals  : mode, sel, in_data, in_valid, in_ready, out_data, out_ch,
//             out_valid, out_ready, err_sel
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_result_mux_pipe_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_valid;
    logic [NCH-1:0]         in_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_ch;
    logic                   out_valid;
    logic                   out_ready;
    logic                   err_sel;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid, err_sel
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid, err_sel
    );
endinterface : alu_result_mux_pipe_if
`default_nettype wire

// File: rtl/alu_result_mux_pipe_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational wrap-around priority search. Returns the first
//             requesting channel at or above ptr, wrapping modulo NCH.
//  Ports    : req         in  NCH   request vector
//             ptr         in  SELW  search start (always < NCH)
//             grant       out SELW  winning channel index
//             grant_valid out 1     at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  wire logic [NCH-1:0]  req,
    input  wire logic [SELW-1:0] ptr,
    output logic      [SELW-1:0] grant,
    output logic                 grant_valid
);

    int w_idx;

    // Scan offsets from farthest to nearest so the nearest hit, written
    // last, wins without needing an early exit.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        w_idx       = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_idx = (int'(ptr) + k) % NCH;
            if (req[w_idx]) begin
                grant       = SELW'(w_idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/alu_result_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_mux_pipe
//  Purpose  : Selects one of NCH result channels (explicit sel or
//             round-robin) and buffers it through a 2-entry skid buffer
//             onto a valid/ready output.
//  Ports    : clk - clock, rising edge
//             rst - asynchronous active-high reset
//             bus - alu_result_mux_pipe_if.slave (mode, sel, in_data,
//                   in_valid, in_ready, out_data, out_ch, out_valid,
//                   out_ready, err_sel)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_mux_pipe
    import alu_mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu_result_mux_pipe_if.slave  bus
);

    occ_state_t         r_state;
    occ_state_t         w_nextState;
    logic [WIDTH-1:0]   r_headData;
    logic [SELW-1:0]    r_headCh;
    logic [WIDTH-1:0]   r_skidData;
    logic [SELW-1:0]    r_skidCh;
    logic [SELW-1:0]    r_ptr;
    logic               r_errSel;

    logic [SELW-1:0]    w_rrGrant;
    logic               w_rrValid;
    logic [SELW-1:0]    w_grant;
    logic               w_grantValid;
    logic               w_selInRange;
    logic [NCH-1:0]     w_inReady;
    logic [WIDTH-1:0]   w_pushData;
    logic               w_push;
    logic               w_pop;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rrArbiter (
        .req         (bus.in_valid),
        .ptr         (r_ptr),
        .grant       (w_rrGrant),
        .grant_valid (w_rrValid)
    );

    assign w_selInRange = (int'(bus.sel) < NCH);

    // Explicit mode grants sel regardless of its valid; the handshake
    // itself decides whether a push happens.
    always_comb begin
        if (bus.mode == MODE_RR) begin
            w_grant      = w_rrGrant;
            w_grantValid = w_rrValid;
        end else begin
            w_grant      = bus.sel;
            w_grantValid = w_selInRange;
        end
    end

    // Ready depends only on registered occupancy, never on out_ready.
    // The data mux is a loop so an out-of-range grant never indexes
    // outside in_data.
    always_comb begin
        w_inReady  = '0;
        w_pushData = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == SELW'(i)) begin
                w_inReady[i] = (r_state != TWO) && w_grantValid && !rst;
                w_pushData   = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_push = |(w_inReady & bus.in_valid);
    assign w_pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY: if (w_push) w_nextState = ONE;
            ONE: begin
                if (w_push && !w_pop)      w_nextState = TWO;
                else if (w_pop && !w_push) w_nextState = EMPTY;
            end
            TWO:   if (w_pop) w_nextState = ONE;
            default: w_nextState = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Head always holds the oldest entry; the skid entry only fills when
    // a push arrives while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_headData <= '0;
            r_headCh   <= '0;
            r_skidData <= '0;
            r_skidCh   <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_headData <= w_pushData;
                        r_headCh   <= w_grant;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_headData <= w_pushData;
                        r_headCh   <= w_grant;
                    end else if (w_push) begin
                        r_skidData <= w_pushData;
                        r_skidCh   <= w_grant;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_headData <= r_skidData;
                        r_headCh   <= r_skidCh;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_errSel <= 1'b0;
        end else begin
            if (w_push && bus.mode == MODE_RR) begin
                r_ptr <= (int'(w_grant) == NCH - 1) ? '0 : w_grant + SELW'(1);
            end
            if (bus.mode == MODE_EXPLICIT && !w_selInRange) begin
                r_errSel <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = (r_state != EMPTY);
    assign bus.out_data  = r_headData;
    assign bus.out_ch    = r_headCh;
    assign bus.err_sel   = r_errSel;

endmodule : alu_result_mux_pipe
`default_nettype wire

// File: tb/tb_alu_result_mux_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_mux_pipe
//  Purpose  : Self-checking bench for alu_result_mux_pipe. Instance A
//             (NCH=4) is compared every cycle against a queue-based model;
//             instance B (NCH=3) exercises the out-of-range select flag.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_mux_pipe;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    alu_result_mux_pipe_if #(.WIDTH(4), .NCH(4), .SELW(2)) busA ();
    alu_result_mux_pipe_if #(.WIDTH(4), .NCH(3), .SELW(2)) busB ();

    alu_result_mux_pipe #(.WIDTH(4), .NCH(4), .SELW(2)) u_dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    alu_result_mux_pipe #(.WIDTH(4), .NCH(3), .SELW(2)) u_dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of instance A: FIFO of ch*16+data and the round-robin pointer.
    int q[$];
    int mPtr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] expReady();
        logic [3:0] r;
        int idx;
        r = '0;
        if (q.size() >= 2) return r;
        if (busA.mode == 1'b0) begin
            r[busA.sel] = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = (mPtr + k) % 4;
                if (busA.in_valid[idx]) begin
                    r[idx] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    // Entered just after a negedge with inputs already driven; returns at
    // the following negedge.
    task automatic cycle();
        logic [3:0] er;
        int  g;
        int  d;
        bit  push;
        bit  pop;
        bit  rrMode;
        #1;
        er = expReady();
        chk("in_ready", busA.in_ready, er);
        push   = |(er & busA.in_valid);
        pop    = (q.size() > 0) && busA.out_ready;
        rrMode = busA.mode;
        g = 0;
        for (int i = 0; i < 4; i++) if (er[i]) g = i;
        d = int'(busA.in_data[g*4 +: 4]);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(g * 16 + d);
            if (rrMode) mPtr = (g + 1) % 4;
        end
        #1;
        chk("out_valid", busA.out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_data", busA.out_data, q[0] % 16);
            chk("out_ch", busA.out_ch, q[0] / 16);
        end
        chk("err_sel_A", busA.err_sel, 1'b0);
        @(negedge clk);
    endtask

    task automatic driveA(input logic m, input logic [1:0] s, input logic [3:0] v,
                          input logic [15:0] d, input logic ordy);
        busA.mode      = m;
        busA.sel       = s;
        busA.in_valid  = v;
        busA.in_data   = d;
        busA.out_ready = ordy;
    endtask

    task automatic syncReset();
        rst = 1'b1;
        q.delete();
        mPtr = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        driveA(1'b0, 2'd2, 4'b0100, 16'h0A00, 1'b1);
        busB.mode = 1'b0; busB.sel = 2'd0; busB.in_valid = '0;
        busB.in_data = '0; busB.out_ready = 1'b1;

        // Reset state, with a grantable request present.
        #2;
        chk("rst_in_ready", busA.in_ready, 4'b0000);
        chk("rst_out_valid", busA.out_valid, 1'b0);
        chk("rst_out_data", busA.out_data, 4'h0);
        chk("rst_out_ch", busA.out_ch, 2'd0);
        chk("rst_err_sel", busA.err_sel, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Explicit sel=2, single-cycle valid.
        driveA(1'b0, 2'd2, 4'b0100, 16'h0A00, 1'b1);
        cycle();
        chk("expl_data_A", busA.out_data, 4'hA);
        chk("expl_ch_2", busA.out_ch, 2'd2);
        driveA(1'b0, 2'd2, 4'b0000, 16'h0000, 1'b1);
        cycle();

        // Backpressure: ch1 streams 1,2,3 with out_ready low, then drains.
        driveA(1'b0, 2'd1, 4'b0010, 16'h0010, 1'b0); cycle();
        driveA(1'b0, 2'd1, 4'b0010, 16'h0020, 1'b0); cycle();
        driveA(1'b0, 2'd1, 4'b0010, 16'h0030, 1'b0); cycle();
        chk("full_hold_data", busA.out_data, 4'h1);
        driveA(1'b0, 2'd1, 4'b0010, 16'h0030, 1'b1); cycle();
        driveA(1'b0, 2'd1, 4'b0010, 16'h0030, 1'b1); cycle();
        driveA(1'b0, 2'd1, 4'b0000, 16'h0000, 1'b1); cycle();
        driveA(1'b0, 2'd1, 4'b0000, 16'h0000, 1'b1); cycle();

        // Round-robin from ptr=0 with all channels valid.
        syncReset();
        repeat (5) begin
            driveA(1'b1, 2'd0, 4'b1111, 16'h3210, 1'b1);
            cycle();
        end
        // Steer ptr to 3, then only ch3 and ch0 request.
        driveA(1'b1, 2'd0, 4'b0100, 16'h3210, 1'b1); cycle();
        driveA(1'b1, 2'd0, 4'b1001, 16'h3210, 1'b1); cycle();
        chk("rr_grant3", busA.out_ch, 2'd3);
        driveA(1'b1, 2'd0, 4'b1001, 16'h3210, 1'b1); cycle();
        chk("rr_wrap0", busA.out_ch, 2'd0);
        driveA(1'b1, 2'd0, 4'b0000, 16'h3210, 1'b1); cycle();

        // Out-of-range explicit select on the NCH=3 instance.
        busB.sel = 2'd3; busB.in_valid = 3'b111; busB.in_data = 12'h765;
        #1;
        chk("errB_in_ready", busB.in_ready, 3'b000);
        chk("errB_pre", busB.err_sel, 1'b0);
        @(posedge clk); #1;
        chk("errB_set", busB.err_sel, 1'b1);
        @(negedge clk);
        busB.sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("errB_sticky", busB.err_sel, 1'b1);
        busB.in_valid = '0;

        // Fill A to two entries, then assert reset between clock edges.
        driveA(1'b0, 2'd1, 4'b0010, 16'h0050, 1'b0); cycle();
        driveA(1'b0, 2'd1, 4'b0010, 16'h0060, 1'b0); cycle();
        #2;
        rst = 1'b1;
        q.delete();
        mPtr = 0;
        #1;
        chk("arst_out_valid", busA.out_valid, 1'b0);
        chk("arst_out_data", busA.out_data, 4'h0);
        chk("arst_out_ch", busA.out_ch, 2'd0);
        chk("arst_errB", busB.err_sel, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        driveA(1'b0, 2'd1, 4'b0010, 16'h0090, 1'b1); cycle();
        chk("arst_new_data", busA.out_data, 4'h9);
        driveA(1'b0, 2'd1, 4'b0000, 16'h0000, 1'b1); cycle();
        chk("arst_no_stale", busA.out_valid, 1'b0);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            driveA(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   4'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
            cycle();
        end
        driveA(1'b0, 2'd0, 4'b0000, 16'h0000, 1'b1);
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_result_mux_pipe
`default_nettype wire
